// File: rtl/bram_result_checker.sv
// Self-check engine: walks a result BRAM and a golden BRAM in lockstep,
// counts mismatching words and captures the first failing word.
module bram_result_checker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              stop_on_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_dut,
  output logic [DATA_W-1:0] first_err_gold,
  output logic              dut_en,
  output logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_dout,
  output logic              gold_en,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic                abort_q, abort_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
  logic [DATA_W-1:0]   first_dut_q, first_dut_d;
  logic [DATA_W-1:0]   first_gold_q, first_gold_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [ADDR_W-1:0]   apipe_q [RD_LAT];
  logic [ADDR_W-1:0]   apipe_d [RD_LAT];

  logic cmp_valid;
  logic mismatch;
  logic stop_now;
  logic issue_en;
  logic pipe_empty_d;

  always_comb begin
    // A mismatch in stop mode must suppress the address being issued this very cycle.
    cmp_valid = vld_q[RD_LAT-1] && !abort_q;
    mismatch  = cmp_valid && (dut_dout != gold_dout);
    stop_now  = stop_q && mismatch;
    issue_en  = (state_q == ISSUE) && !stop_now;

    vld_d[0]   = issue_en;
    apipe_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      apipe_d[i] = apipe_q[i-1];
    end
    pipe_empty_d = (vld_d == '0);

    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    stop_d       = stop_q;
    abort_d      = abort_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    first_addr_d = first_addr_q;
    first_dut_d  = first_dut_q;
    first_gold_d = first_gold_q;

    if (mismatch) begin
      if (err_cnt_q == '0) begin
        first_addr_d = apipe_q[RD_LAT-1];
        first_dut_d  = dut_dout;
        first_gold_d = gold_dout;
      end
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (stop_now) abort_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_cnt_d    = '0;
          first_addr_d = '0;
          first_dut_d  = '0;
          first_gold_d = '0;
          pass_d       = 1'b0;
          abort_d      = 1'b0;
          stop_d       = stop_on_err;
          len_d        = len;
          addr_d       = base_addr;
          cnt_d        = '0;
          state_d      = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (stop_now) begin
          state_d = pipe_empty_d ? DONE : DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) pass_d = (err_cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      stop_q       <= 1'b0;
      abort_q      <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_addr_q <= '0;
      first_dut_q  <= '0;
      first_gold_q <= '0;
      vld_q        <= '0;
      apipe_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      stop_q       <= stop_d;
      abort_q      <= abort_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_addr_q <= first_addr_d;
      first_dut_q  <= first_dut_d;
      first_gold_q <= first_gold_d;
      vld_q        <= vld_d;
      apipe_q      <= apipe_d;
    end
  end

  assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_addr_q;
  assign first_err_dut  = first_dut_q;
  assign first_err_gold = first_gold_q;
  assign dut_en         = issue_en;
  assign gold_en        = issue_en;
  assign dut_addr       = addr_q;
  assign gold_addr      = addr_q;

endmodule

// File: tb/tb_bram_result_checker.sv
// Bench for bram_result_checker: three instances (default, RD_LAT=3, ERR_W=2)
// share stimulus and memory contents, each with its own BRAM read pipeline.
module tb_bram_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [9:0] baseIn = '0;
  logic [10:0] lenIn = '0;
  logic stopIn = 1'b0;

  logic [7:0] goldMem [1024];
  logic [7:0] dutMem [1024];

  logic busy0, done0, pass0, en0, gen0;
  logic [15:0] err0;
  logic [9:0] fea0, addr0, gaddr0;
  logic [7:0] fed0, feg0, dd0, gd0;

  logic busy1, done1, pass1, en1, gen1;
  logic [15:0] err1;
  logic [9:0] fea1, addr1, gaddr1;
  logic [7:0] fed1, feg1;
  logic [7:0] dd1a, dd1b, dd1c, gd1a, gd1b, gd1c;

  logic busy2, done2, pass2, en2, gen2;
  logic [1:0] err2;
  logic [9:0] fea2, addr2, gaddr2;
  logic [7:0] fed2, feg2, dd2, gd2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int startCyc = 0;
  int t0, t1, t2;
  int doneCnt0 = 0;
  int addrQ[$];

  bram_result_checker u0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(baseIn), .len(lenIn),
    .stop_on_err(stopIn), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_err_addr(fea0), .first_err_dut(fed0),
    .first_err_gold(feg0), .dut_en(en0), .dut_addr(addr0), .dut_dout(dd0),
    .gold_en(gen0), .gold_addr(gaddr0), .gold_dout(gd0)
  );

  bram_result_checker #(.RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(baseIn), .len(lenIn),
    .stop_on_err(stopIn), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_addr(fea1), .first_err_dut(fed1),
    .first_err_gold(feg1), .dut_en(en1), .dut_addr(addr1), .dut_dout(dd1c),
    .gold_en(gen1), .gold_addr(gaddr1), .gold_dout(gd1c)
  );

  bram_result_checker #(.ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(baseIn), .len(lenIn),
    .stop_on_err(stopIn), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_err_addr(fea2), .first_err_dut(fed2),
    .first_err_gold(feg2), .dut_en(en2), .dut_addr(addr2), .dut_dout(dd2),
    .gold_en(gen2), .gold_addr(gaddr2), .gold_dout(gd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM read models: one registered stage, or three for the RD_LAT=3 instance.
  always @(posedge clk) begin
    if (en0) dd0 <= dutMem[addr0];
    if (gen0) gd0 <= goldMem[gaddr0];
    if (en2) dd2 <= dutMem[addr2];
    if (gen2) gd2 <= goldMem[gaddr2];
    if (en1) dd1a <= dutMem[addr1];
    if (gen1) gd1a <= goldMem[gaddr1];
    dd1b <= dd1a;
    dd1c <= dd1b;
    gd1b <= gd1a;
    gd1c <= gd1b;
  end

  always @(negedge clk) begin
    if (en0) addrQ.push_back(int'(addr0));
    if (done0) doneCnt0 <= doneCnt0 + 1;
  end

  typedef struct {
    int base;
    int len;
    bit stop;
    int nbad;
    logic [5:0][9:0] bad;
    int expErr;
    int expErr2;
    bit expPass;
    int expFirst;
    int expDone0;
    int expDone1;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] goldVal(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic vec_t mk(input int base, input int len, input bit stop,
                              input int nbad, input int b0, input int b1,
                              input int b2, input int b3, input int b4,
                              input int b5, input int e, input int e2,
                              input bit p, input int first, input int d0,
                              input int d1);
    vec_t v;
    v.base = base; v.len = len; v.stop = stop; v.nbad = nbad;
    v.bad[0] = 10'(b0); v.bad[1] = 10'(b1); v.bad[2] = 10'(b2);
    v.bad[3] = 10'(b3); v.bad[4] = 10'(b4); v.bad[5] = 10'(b5);
    v.expErr = e; v.expErr2 = e2; v.expPass = p; v.expFirst = first;
    v.expDone0 = d0; v.expDone1 = d1;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setupMem(input vec_t v);
    for (int i = 0; i < 1024; i++) begin
      goldMem[i] = goldVal(i);
      dutMem[i]  = goldVal(i);
    end
    for (int j = 0; j < v.nbad; j++) dutMem[v.bad[j]] = goldVal(int'(v.bad[j])) ^ 8'h5A;
  endtask

  // Polls on negedges until every instance has pulsed done, bounded at 400 cycles.
  task automatic waitDone();
    t0 = -1; t1 = -1; t2 = -1;
    for (int n = 0; n < 400 && (t0 < 0 || t1 < 0 || t2 < 0); n++) begin
      if (done0 && t0 < 0) t0 = cyc - startCyc;
      if (done1 && t1 < 0) t1 = cyc - startCyc;
      if (done2 && t2 < 0) t2 = cyc - startCyc;
      @(negedge clk);
    end
  endtask

  task automatic pulseStart(input int base, input int len, input bit stop);
    baseIn = 10'(base);
    lenIn  = 11'(len);
    stopIn = stop;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    setupMem(v);
    @(negedge clk);
    addrQ.delete();
    startCyc = cyc;
    pulseStart(v.base, v.len, v.stop);
    waitDone();
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string p;
    logic [7:0] g;
    p = $sformatf("v%0d", idx);
    g = goldVal(v.expFirst);
    check({p, " done0 cycle"}, t0, v.expDone0);
    check({p, " done1 cycle"}, t1, v.expDone1);
    check({p, " done2 cycle"}, t2, v.expDone0);
    check({p, " err_cnt"}, err0, v.expErr);
    check({p, " err_cnt rdlat3"}, err1, v.expErr);
    check({p, " err_cnt errw2"}, err2, v.expErr2);
    check({p, " pass"}, pass0, v.expPass);
    check({p, " pass rdlat3"}, pass1, v.expPass);
    check({p, " pass errw2"}, pass2, v.expPass);
    check({p, " first_err_addr"}, fea0, (v.expErr != 0) ? v.expFirst : 0);
    check({p, " first_err_addr rdlat3"}, fea1, (v.expErr != 0) ? v.expFirst : 0);
    check({p, " first_err_dut"}, fed0, (v.expErr != 0) ? longint'(g ^ 8'h5A) : 0);
    check({p, " first_err_gold"}, feg0, (v.expErr != 0) ? longint'(g) : 0);
    check({p, " busy after done"}, busy0, 0);
  endtask

  initial begin
    vecs[0] = mk(0, 294, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 296, 298);
    vecs[1] = mk(0, 294, 0, 3, 5, 100, 293, 0, 0, 0, 3, 3, 0, 5, 296, 298);
    vecs[2] = mk(0, 294, 1, 3, 5, 100, 293, 0, 0, 0, 1, 1, 0, 5, 8, 12);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    vecs[4] = mk(0, 20, 0, 6, 2, 4, 6, 8, 10, 12, 6, 3, 0, 2, 22, 24);
    vecs[5] = mk(0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12, 14);
    vecs[6] = mk(1020, 8, 0, 2, 1022, 1, 0, 0, 0, 0, 2, 2, 0, 1022, 10, 12);
    vecs[7] = mk(1020, 8, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 8, 12);

    setupMem(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset pass", pass0, 0);
    check("reset err_cnt", err0, 0);
    check("reset en", en0, 0);
    check("reset addr", addr0, 0);
    check("reset first_err_addr", fea0, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Wrapping run: addresses must go 1020..1023 then 0..3.
    applyStimulus(vecs[6]);
    check("wrap issue count", addrQ.size(), 8);
    for (int k = 0; k < 8 && k < addrQ.size(); k++)
      check($sformatf("wrap addr %0d", k), addrQ[k], (1020 + k) % 1024);

    // Stop mode: the last address issued is the failing one.
    applyStimulus(vecs[2]);
    check("stop issue count", addrQ.size(), 6);
    if (addrQ.size() > 0) check("stop last addr", addrQ[addrQ.size()-1], 5);

    // Reset in the middle of a long run aborts it without a done pulse.
    setupMem(vecs[0]);
    @(negedge clk);
    startCyc = cyc;
    pulseStart(0, 294, 0);
    while (cyc < startCyc + 50) @(negedge clk);
    check("busy mid-run", busy0, 1);
    begin
      int dc;
      rst = 1'b1;
      #1;
      check("midrst busy", busy0, 0);
      check("midrst en", en0, 0);
      check("midrst addr", addr0, 0);
      check("midrst err_cnt", err0, 0);
      check("midrst pass", pass0, 0);
      check("midrst busy rdlat3", busy1, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dc = doneCnt0;
      repeat (300) @(negedge clk);
      check("midrst no done", doneCnt0 - dc, 0);
    end
    applyStimulus(vecs[1]);
    checkOutput(8, vecs[1]);

    // A start while busy must not disturb the run in progress.
    setupMem(mk(0, 20, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 3, 22, 24));
    @(negedge clk);
    addrQ.delete();
    startCyc = cyc;
    pulseStart(0, 20, 0);
    repeat (4) @(negedge clk);
    pulseStart(500, 3, 1);
    waitDone();
    check("busy-start done cycle", t0, 22);
    check("busy-start err_cnt", err0, 1);
    check("busy-start first addr", fea0, 3);
    check("busy-start issue count", addrQ.size(), 20);
    if (addrQ.size() > 0) check("busy-start last addr", addrQ[addrQ.size()-1], 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
